// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, states,
// ALU/mux select codes and the control word driven to the datapath.
package ctrl_pkg;

    localparam int unsigned OP_W    = 6;
    localparam int unsigned STATE_W = 4;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
    localparam logic [OP_W-1:0] OP_ADDIU = 6'b001001;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_WB_MEM   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC_R   = 4'd6,
        S_EXEC_I   = 4'd7,
        S_WB_ALU   = 4'd8,
        S_BRANCH   = 4'd9,
        S_JUMP     = 4'd10
    } state_t;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_FUNCT = 3'b001;
    localparam logic [2:0] ALU_OR    = 3'b010;
    localparam logic [2:0] ALU_SUB   = 3'b100;

    localparam logic [1:0] SRCB_RT   = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_BR   = 2'b11;

    localparam logic [1:0] PCSEL_ALU  = 2'b00;
    localparam logic [1:0] PCSEL_OUT  = 2'b01;
    localparam logic [1:0] PCSEL_JUMP = 2'b10;

    typedef struct packed {
        logic       pc_wr;
        logic       ir_wr;
        logic       i_or_d;
        logic       mem_rd;
        logic       mem_wr;
        logic       reg_dst;
        logic       reg_wr;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       ext_op;
        logic [2:0] alu_op;
        logic [1:0] pc_sel;
    } ctrl_word_t;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath/memory signal bundle.
interface multicycle_ctrl_if;
    logic [5:0] op;
    logic       Zero;
    logic       Overflow;
    logic       mem_ready;
    logic       PCWr;
    logic       IRWr;
    logic       IorD;
    logic       MemRd;
    logic       MemWr;
    logic       RegDst;
    logic       RegWr;
    logic       MemtoReg;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic       Extop;
    logic [2:0] ALUop;
    logic [1:0] PC_Sel;
    logic       bus_err;
    logic [3:0] state;

    modport master (
        input  op, Zero, Overflow, mem_ready,
        output PCWr, IRWr, IorD, MemRd, MemWr, RegDst, RegWr, MemtoReg,
               ALUSrcA, ALUSrcB, Extop, ALUop, PC_Sel, bus_err, state
    );

    modport slave (
        output op, Zero, Overflow, mem_ready,
        input  PCWr, IRWr, IorD, MemRd, MemWr, RegDst, RegWr, MemtoReg,
               ALUSrcA, ALUSrcB, Extop, ALUop, PC_Sel, bus_err, state
    );
endinterface

// File: rtl/ctrl_out_decode.sv
// Combinational control-word decode from the current step plus the
// ready/zero/overflow qualifiers that gate the write enables.
module ctrl_out_decode
    import ctrl_pkg::*;
(
    input  state_t          state,
    input  logic [OP_W-1:0] op,
    input  logic            mem_ready,
    input  logic            zero,
    input  logic            ovf_q,
    input  logic            dst_rd_q,
    output ctrl_word_t      ctrl_c
);

    always_comb begin
        ctrl_c = '0;
        case (state)
            S_FETCH: begin
                ctrl_c.mem_rd    = 1'b1;
                ctrl_c.alu_src_b = SRCB_FOUR;
                ctrl_c.ir_wr     = mem_ready;
                ctrl_c.pc_wr     = mem_ready;
            end
            S_DECODE: begin
                ctrl_c.alu_src_b = SRCB_BR;
                ctrl_c.ext_op    = 1'b1;
            end
            S_EXEC_R: begin
                ctrl_c.alu_src_a = 1'b1;
                ctrl_c.alu_op    = ALU_FUNCT;
            end
            S_EXEC_I: begin
                ctrl_c.alu_src_a = 1'b1;
                ctrl_c.alu_src_b = SRCB_IMM;
                if (op == OP_ORI) begin
                    ctrl_c.alu_op = ALU_OR;
                end else begin
                    ctrl_c.ext_op = 1'b1;
                end
            end
            // Overflowed arithmetic completes without touching the register file.
            S_WB_ALU: begin
                ctrl_c.reg_wr  = ~ovf_q;
                ctrl_c.reg_dst = dst_rd_q;
            end
            S_MEM_ADDR: begin
                ctrl_c.alu_src_a = 1'b1;
                ctrl_c.alu_src_b = SRCB_IMM;
                ctrl_c.ext_op    = 1'b1;
            end
            S_MEM_RD: begin
                ctrl_c.i_or_d = 1'b1;
                ctrl_c.mem_rd = 1'b1;
            end
            S_WB_MEM: begin
                ctrl_c.reg_wr     = 1'b1;
                ctrl_c.mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                ctrl_c.i_or_d = 1'b1;
                ctrl_c.mem_wr = 1'b1;
            end
            S_BRANCH: begin
                ctrl_c.alu_src_a = 1'b1;
                ctrl_c.alu_op    = ALU_SUB;
                ctrl_c.pc_sel    = PCSEL_OUT;
                ctrl_c.pc_wr     = zero;
            end
            S_JUMP: begin
                ctrl_c.pc_sel = PCSEL_JUMP;
                ctrl_c.pc_wr  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control FSM with memory wait-state handshake and
// bounded-wait timeout that aborts to FETCH with a bus_err pulse.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 15,
    parameter int unsigned WAIT_W   = 8
)
(
    input  logic               clk,
    input  logic               rst_n,
    multicycle_ctrl_if.master  bus
);

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              ovf_q, ovf_d;
    logic              dst_rd_q, dst_rd_d;
    logic              req_c;
    logic              timeout_c;
    ctrl_word_t        ctrl_c;

    assign req_c     = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
    assign timeout_c = req_c && !bus.mem_ready && (wait_q == WAIT_W'(MAX_WAIT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_FETCH;
            wait_q   <= '0;
            ovf_q    <= 1'b0;
            dst_rd_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            ovf_q    <= ovf_d;
            dst_rd_q <= dst_rd_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        wait_d   = '0;
        ovf_d    = ovf_q;
        dst_rd_d = dst_rd_q;
        case (state_q)
            S_FETCH: begin
                if (bus.mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                case (bus.op)
                    OP_RTYPE:        state_d = S_EXEC_R;
                    OP_ORI, OP_ADDIU: state_d = S_EXEC_I;
                    OP_LW, OP_SW:    state_d = S_MEM_ADDR;
                    OP_BEQ:          state_d = S_BRANCH;
                    OP_J:            state_d = S_JUMP;
                    default:         state_d = S_FETCH;
                endcase
            end
            S_MEM_ADDR: state_d = (bus.op == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD: begin
                if (bus.mem_ready)  state_d = S_WB_MEM;
                else if (timeout_c) state_d = S_FETCH;
            end
            S_MEM_WR: begin
                if (bus.mem_ready || timeout_c) state_d = S_FETCH;
            end
            S_EXEC_R: begin
                ovf_d    = bus.Overflow;
                dst_rd_d = 1'b1;
                state_d  = S_WB_ALU;
            end
            S_EXEC_I: begin
                ovf_d    = (bus.op == OP_ORI) ? 1'b0 : bus.Overflow;
                dst_rd_d = 1'b0;
                state_d  = S_WB_ALU;
            end
            S_WB_ALU, S_WB_MEM, S_BRANCH, S_JUMP: state_d = S_FETCH;
            default: state_d = S_FETCH;
        endcase
        // Count only while a request stays pending in the same step; any
        // step change, ready or timeout restarts the count from zero.
        if (req_c && !bus.mem_ready && !timeout_c && (state_d == state_q)) begin
            wait_d = wait_q + WAIT_W'(1);
        end
    end

    ctrl_out_decode u_decode (
        .state    (state_q),
        .op       (bus.op),
        .mem_ready(bus.mem_ready),
        .zero     (bus.Zero),
        .ovf_q    (ovf_q),
        .dst_rd_q (dst_rd_q),
        .ctrl_c   (ctrl_c)
    );

    // Side-effecting enables are held off for the whole reset assertion.
    assign bus.PCWr     = ctrl_c.pc_wr  & rst_n;
    assign bus.IRWr     = ctrl_c.ir_wr  & rst_n;
    assign bus.MemRd    = ctrl_c.mem_rd & rst_n;
    assign bus.MemWr    = ctrl_c.mem_wr & rst_n;
    assign bus.RegWr    = ctrl_c.reg_wr & rst_n;
    assign bus.bus_err  = timeout_c     & rst_n;
    assign bus.IorD     = ctrl_c.i_or_d;
    assign bus.RegDst   = ctrl_c.reg_dst;
    assign bus.MemtoReg = ctrl_c.mem_to_reg;
    assign bus.ALUSrcA  = ctrl_c.alu_src_a;
    assign bus.ALUSrcB  = ctrl_c.alu_src_b;
    assign bus.Extop    = ctrl_c.ext_op;
    assign bus.ALUop    = ctrl_c.alu_op;
    assign bus.PC_Sel   = ctrl_c.pc_sel;
    assign bus.state    = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench: each instruction is expanded into a per-cycle script
// of expected steps and outputs, then replayed against the controller.
module tb_multicycle_ctrl;

    localparam int MAX_WAIT = 15;

    localparam logic [5:0] RTYPE = 6'b000000;
    localparam logic [5:0] ORI   = 6'b001101;
    localparam logic [5:0] ADDIU = 6'b001001;
    localparam logic [5:0] LW    = 6'b100011;
    localparam logic [5:0] SW    = 6'b101011;
    localparam logic [5:0] BEQ   = 6'b000100;
    localparam logic [5:0] JMP   = 6'b000010;

    typedef struct packed {
        logic       pcwr, irwr, iord, memrd, memwr, regdst, regwr, memtoreg, srca;
        logic [1:0] srcb;
        logic       extop;
        logic [2:0] aluop;
        logic [1:0] pcsel;
        logic       berr;
    } ctl_t;

    typedef struct {
        logic [5:0] op;
        logic       rdy, zero, ovf;
        logic [3:0] st;
        ctl_t       c;
    } step_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    logic [5:0] cur_op = '0;
    step_t q[$];

    multicycle_ctrl_if bus ();

    multicycle_ctrl #(.MAX_WAIT(MAX_WAIT), .WAIT_W(8)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic step_t base(input logic [3:0] st);
        step_t s;
        s.op   = cur_op;
        s.rdy  = 1'($urandom);
        s.zero = 1'($urandom);
        s.ovf  = 1'($urandom);
        s.st   = st;
        s.c    = '0;
        return s;
    endfunction

    // Instruction fetch with d wait cycles; d > MAX_WAIT means it times out.
    task automatic add_fetch(input int d);
        step_t s;
        int n = (d > MAX_WAIT) ? MAX_WAIT : d;
        for (int i = 0; i <= n; i++) begin
            s = base(4'd0);
            s.c.memrd = 1'b1;
            s.c.srcb  = 2'b01;
            s.rdy     = (d <= MAX_WAIT) && (i == d);
            s.c.pcwr  = s.rdy;
            s.c.irwr  = s.rdy;
            s.c.berr  = (d > MAX_WAIT) && (i == MAX_WAIT);
            q.push_back(s);
        end
    endtask

    task automatic add_mem(input logic [3:0] st, input int d, output bit done);
        step_t s;
        int n = (d > MAX_WAIT) ? MAX_WAIT : d;
        done = (d <= MAX_WAIT);
        for (int i = 0; i <= n; i++) begin
            s = base(st);
            s.c.iord  = 1'b1;
            s.c.memrd = (st == 4'd3);
            s.c.memwr = (st == 4'd5);
            s.rdy     = done && (i == d);
            s.c.berr  = !done && (i == MAX_WAIT);
            q.push_back(s);
        end
    endtask

    task automatic build(input logic [5:0] op, input int fd, input int md,
                         input logic z, input logic ov);
        step_t s;
        bit    ok;
        cur_op = op;
        add_fetch(fd);
        if (fd > MAX_WAIT) add_fetch(0);
        s = base(4'd1); s.c.srcb = 2'b11; s.c.extop = 1'b1; q.push_back(s);
        case (op)
            RTYPE, ORI, ADDIU: begin
                s = base((op == RTYPE) ? 4'd6 : 4'd7);
                s.c.srca = 1'b1;
                s.ovf    = ov;
                if (op == RTYPE) s.c.aluop = 3'b001;
                else begin
                    s.c.srcb  = 2'b10;
                    s.c.extop = (op == ADDIU);
                    s.c.aluop = (op == ORI) ? 3'b010 : 3'b000;
                end
                q.push_back(s);
                s = base(4'd8);
                s.c.regwr  = (op == ORI) ? 1'b1 : ~ov;
                s.c.regdst = (op == RTYPE);
                q.push_back(s);
            end
            LW, SW: begin
                s = base(4'd2); s.c.srca = 1'b1; s.c.srcb = 2'b10; s.c.extop = 1'b1;
                q.push_back(s);
                add_mem((op == LW) ? 4'd3 : 4'd5, md, ok);
                if (op == LW && ok) begin
                    s = base(4'd4); s.c.regwr = 1'b1; s.c.memtoreg = 1'b1; q.push_back(s);
                end
            end
            BEQ: begin
                s = base(4'd9); s.zero = z; s.c.srca = 1'b1; s.c.aluop = 3'b100;
                s.c.pcsel = 2'b01; s.c.pcwr = z; q.push_back(s);
            end
            JMP: begin
                s = base(4'd10); s.c.pcsel = 2'b10; s.c.pcwr = 1'b1; q.push_back(s);
            end
            default: ;
        endcase
    endtask

    function automatic ctl_t observed();
        ctl_t o;
        o = {bus.PCWr, bus.IRWr, bus.IorD, bus.MemRd, bus.MemWr, bus.RegDst, bus.RegWr,
             bus.MemtoReg, bus.ALUSrcA, bus.ALUSrcB, bus.Extop, bus.ALUop, bus.PC_Sel,
             bus.bus_err};
        return o;
    endfunction

    // Replay the script one cycle per entry; called just after a rising edge.
    task automatic play();
        step_t s;
        while (q.size() > 0) begin
            s = q.pop_front();
            bus.op        = s.op;
            bus.mem_ready = s.rdy;
            bus.Zero      = s.zero;
            bus.Overflow  = s.ovf;
            @(negedge clk);
            check($sformatf("state(op%02h)", s.op), 32'(bus.state), 32'(s.st));
            check($sformatf("ctrl(st%0d)", s.st), 32'(observed()), 32'(s.c));
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_reset_enables(input string tag);
        check({tag, " enables"}, 32'({bus.PCWr, bus.IRWr, bus.MemRd, bus.MemWr, bus.RegWr, bus.bus_err}), 32'(0));
        check({tag, " state"}, 32'(bus.state), 32'(0));
    endtask

    logic [5:0] ops[11] = '{RTYPE, ORI, ADDIU, LW, SW, BEQ, JMP, 6'h3F, 6'h08, 6'h0F, 6'h20};
    int fd, md;

    initial begin
        bus.op = '0; bus.mem_ready = 1'b1; bus.Zero = 1'b0; bus.Overflow = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_enables("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        build(ADDIU, 0, 0, 1'b0, 1'b0);        play();
        build(LW,    0, 3, 1'b0, 1'b0);        play();
        build(BEQ,   0, 0, 1'b1, 1'b0);        play();
        build(BEQ,   0, 0, 1'b0, 1'b0);        play();
        build(RTYPE, 0, 0, 1'b0, 1'b1);        play();
        build(SW,    0, 16, 1'b0, 1'b0);       play();
        build(JMP,   1, 0, 1'b0, 1'b0);        play();
        build(ORI,   0, 0, 1'b0, 1'b1);        play();
        build(6'h3F, 2, 0, 1'b0, 1'b0);        play();
        build(ADDIU, 16, 0, 1'b0, 1'b1);       play();
        build(LW,    0, 15, 1'b0, 1'b0);       play();
        build(LW,    15, 16, 1'b0, 1'b0);      play();
        build(SW,    0, 15, 1'b0, 1'b0);       play();

        for (int i = 0; i < 80; i++) begin
            fd = ($urandom_range(0, 7) == 0) ? int'($urandom_range(14, 17)) : int'($urandom_range(0, 3));
            md = ($urandom_range(0, 7) == 0) ? int'($urandom_range(14, 17)) : int'($urandom_range(0, 3));
            build(ops[$urandom_range(0, 10)], fd, md, 1'($urandom), 1'($urandom));
            play();
        end

        // Abort an R-type while it sits in EXEC_R.
        build(RTYPE, 0, 0, 1'b0, 1'b0);
        void'(q.pop_back());
        void'(q.pop_back());
        play();
        check("pre-reset state", 32'(bus.state), 32'(6));
        bus.mem_ready = 1'b1;
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_enables("mid-reset c1");
        @(posedge clk); #1;
        @(negedge clk);
        check_reset_enables("mid-reset c2");
        @(posedge clk); #1;
        rst_n = 1'b1;
        build(ADDIU, 0, 0, 1'b0, 1'b0);
        play();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
